freq_sel_glitchfree: RTL and testbench



---
 rtl/freq_sel_pkg.sv | 20 ++
 rtl/freq_div_counter.sv | 20 ++
 rtl/freq_sel_glitchfree.sv | 97 +++++++++
 tb/tb_freq_sel_glitchfree.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_sel_pkg.sv
// freq_sel_pkg: shared FSM encoding, default sizes and clog2 helper for freq_sel_glitchfree.
package freq_sel_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam int DIV_W_DEF    = 15;
    localparam int N_TAPS_DEF   = 8;
    localparam int TAP_BASE_DEF = 7;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/freq_div_counter.sv
// freq_div_counter: DIV_W-bit enabled free-running prescaler, wraps modulo 2**DIV_W.
module freq_div_counter
    import freq_sel_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    output logic [DIV_W-1:0] cnt
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            cnt <= '0;
        else if (En)
            cnt <= cnt + DIV_W'(1);
    end

endmodule

// File: rtl/freq_sel_glitchfree.sv
// freq_sel_glitchfree: stepped tap selector on a prescaler with tap changes deferred to a common low point.
// Define SEL_WRAP_EN to wrap the selection at both ends instead of saturating.
module freq_sel_glitchfree
    import freq_sel_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int N_TAPS   = N_TAPS_DEF,
    parameter int TAP_BASE = TAP_BASE_DEF,
    parameter int SEL_INIT = 0,
    parameter int SEL_W    = clog2(N_TAPS)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Down,
    output logic             Fsw,
    output logic             Tick,
    output logic [SEL_W-1:0] Sel_out,
    output logic             Busy
);

    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_TAPS - 1);
    localparam logic [SEL_W-1:0] SEL_RST = SEL_W'(SEL_INIT);

    logic [DIV_W-1:0]  cnt;
    logic [N_TAPS-1:0] taps;
    logic              cnt_unused;
    state_t            state, state_nx;
    logic [SEL_W-1:0]  sel_cur, sel_pend, sel_cur_nx, sel_pend_nx, sel_step;
    logic              fsw, tick, tap_cur, tap_pend;
    logic              up_req, dn_req, at_top, at_bot, step_ok, switch_ok;

    freq_div_counter #(.DIV_W(DIV_W)) u_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .En    (En),
        .cnt   (cnt)
    );

    // Sel 0 maps to the highest (slowest) counter bit.
    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
        assign taps[k] = cnt[TAP_BASE + N_TAPS - 1 - k];
    end

    assign cnt_unused = ^cnt;

    always_comb begin
        tap_cur  = taps[sel_cur];
        tap_pend = taps[sel_pend];
        up_req   = Up & ~Down;
        dn_req   = Down & ~Up;
        at_top   = sel_cur == SEL_MAX;
        at_bot   = sel_cur == '0;
`ifdef SEL_WRAP_EN
        step_ok  = up_req | dn_req;
        sel_step = up_req ? (at_top ? '0 : sel_cur + 1'b1) : (at_bot ? SEL_MAX : sel_cur - 1'b1);
`else
        step_ok  = (up_req & ~at_top) | (dn_req & ~at_bot);
        sel_step = up_req ? sel_cur + 1'b1 : sel_cur - 1'b1;
`endif
        // Both taps low and output already low: the new tap can only start a full high phase.
        switch_ok   = (state == ST_PENDING) & ~fsw & ~tap_cur & ~tap_pend;
        state_nx    = state;
        sel_cur_nx  = sel_cur;
        sel_pend_nx = sel_pend;
        if (state == ST_IDLE && step_ok) begin
            state_nx    = ST_PENDING;
            sel_pend_nx = sel_step;
        end else if (switch_ok) begin
            state_nx   = ST_IDLE;
            sel_cur_nx = sel_pend;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            sel_cur  <= SEL_RST;
            sel_pend <= SEL_RST;
            fsw      <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state    <= state_nx;
            sel_cur  <= sel_cur_nx;
            sel_pend <= sel_pend_nx;
            fsw      <= tap_cur;
            tick     <= ~fsw & tap_cur;
        end
    end

    assign Fsw     = fsw;
    assign Tick    = tick;
    assign Sel_out = sel_cur;
    assign Busy    = state == ST_PENDING;

endmodule

// File: tb/tb_freq_sel_glitchfree.sv
// tb_freq_sel_glitchfree: randomized and directed checks of freq_sel_glitchfree against a cycle model.
module tb_freq_sel_glitchfree;

    localparam int DW = 6;
    localparam int NT = 4;
    localparam int TB = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       En = 1'b0;
    logic       Up = 1'b0;
    logic       Down = 1'b0;
    logic       Fsw, Tick, Busy;
    logic [1:0] Sel_out;

    int n_chk = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    freq_sel_glitchfree #(.DIV_W(DW), .N_TAPS(NT), .TAP_BASE(TB), .SEL_INIT(0)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .En      (En),
        .Up      (Up),
        .Down    (Down),
        .Fsw     (Fsw),
        .Tick    (Tick),
        .Sel_out (Sel_out),
        .Busy    (Busy)
    );

    // Reference model: counter as an integer, taps by shifting, selection as plain integers.
    int m_cnt = 0, m_cur = 0, m_pend = 0, m_req = 0;
    bit m_busy = 0, m_fsw = 0, m_tick = 0, m_t, m_sw, m_ok;

    function automatic bit tapv(input int c, input int k);
        return bit'((c >> (TB + NT - 1 - k)) & 1);
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            m_cnt = 0; m_cur = 0; m_pend = 0; m_busy = 0; m_fsw = 0; m_tick = 0;
        end else begin
            m_t  = tapv(m_cnt, m_cur);
            m_sw = m_busy && !m_fsw && !m_t && !tapv(m_cnt, m_pend);
`ifdef SEL_WRAP_EN
            m_req = Up ? (m_cur + 1) % NT : (m_cur + NT - 1) % NT;
            m_ok  = !m_busy && (Up != Down);
`else
            m_req = Up ? m_cur + 1 : m_cur - 1;
            m_ok  = !m_busy && (Up != Down) && m_req >= 0 && m_req < NT;
`endif
            m_tick = !m_fsw && m_t;
            m_fsw  = m_t;
            if (m_sw) begin
                m_cur = m_pend; m_busy = 0;
            end else if (m_ok) begin
                m_pend = m_req; m_busy = 1;
            end
            if (En) m_cnt = (m_cnt + 1) % (1 << DW);
        end
    end

    logic [4:0] exp_v, obs_v;
    assign exp_v = {m_fsw, m_tick, 2'(m_cur), m_busy};
    assign obs_v = {Fsw, Tick, Sel_out, Busy};

    task automatic do_reset;
        Reset = 1'b1; Up = 1'b0; Down = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; En = 1'b1;
        repeat (3) @(negedge Clk);
        n_chk++;
        if (obs_v !== 5'b0) begin
            n_fail++; $display("FAIL reset_vals: got {Fsw,Tick,Sel,Busy}=%b expected 00000", obs_v);
        end
        Reset = 1'b0;
    endtask

    task automatic test_period;
        bit prev = 0;
        int last_rise = -1, hi_start = -1, n_rise = 0;
        En = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL period_model @%0d: got %b expected %b", i, obs_v, exp_v);
            end
            n_chk++;
            if (Tick !== (Fsw && !prev)) begin
                n_fail++; $display("FAIL tick_on_rise @%0d: got Tick=%b expected %b", i, Tick, Fsw && !prev);
            end
            if (Fsw && !prev) begin
                n_rise++;
                if (last_rise >= 0) begin
                    n_chk++;
                    if (i - last_rise != 64) begin
                        n_fail++; $display("FAIL period_64: got %0d expected 64", i - last_rise);
                    end
                end
                last_rise = i; hi_start = i;
            end
            if (!Fsw && prev && hi_start >= 0) begin
                n_chk++;
                if (i - hi_start != 32) begin
                    n_fail++; $display("FAIL high_32: got %0d expected 32", i - hi_start);
                end
            end
            prev = Fsw;
        end
        n_chk++;
        if (n_rise < 3) begin
            n_fail++; $display("FAIL rise_count: got %0d expected >= 3", n_rise);
        end
    endtask

    task automatic test_down_at_zero;
        do_reset();
        En = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL down_model @%0d: got %b expected %b", i, obs_v, exp_v);
            end
`ifdef SEL_WRAP_EN
            if (i == 1) begin
                n_chk++;
                if (Busy !== 1'b1) begin
                    n_fail++; $display("FAIL down_wrap_busy: got %b expected 1", Busy);
                end
            end
`else
            if (i > 0) begin
                n_chk++;
                if (Busy !== 1'b0 || Sel_out !== 2'd0) begin
                    n_fail++; $display("FAIL down_saturate: got Busy=%b Sel=%0d expected 0/0", Busy, Sel_out);
                end
            end
`endif
            Down = (i == 0);
        end
`ifdef SEL_WRAP_EN
        n_chk++;
        if (Sel_out !== 2'd3) begin
            n_fail++; $display("FAIL down_wrap_sel: got %0d expected 3", Sel_out);
        end
`endif
    endtask

    task automatic test_up_glitch;
        bit sent = 0, switched = 0, prev_busy = 0, prev = 0;
        int hi_start = -1;
        do_reset();
        En = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL up_model @%0d: got %b expected %b", i, obs_v, exp_v);
            end
            if (Busy && Fsw) begin
                n_chk++;
                if (Sel_out !== 2'd0) begin
                    n_fail++; $display("FAIL up_sel_held: got %0d expected 0", Sel_out);
                end
            end
            if (prev_busy && !Busy && !switched) begin
                switched = 1;
                n_chk++;
                if (Sel_out !== 2'd1 || Fsw !== 1'b0) begin
                    n_fail++; $display("FAIL up_switch: got Sel=%0d Fsw=%b expected 1/0", Sel_out, Fsw);
                end
            end
            if (Fsw && !prev) hi_start = i;
            if (!Fsw && prev && hi_start >= 0) begin
                n_chk++;
                if (i - hi_start < 16) begin
                    n_fail++; $display("FAIL runt_pulse: got %0d expected >= 16", i - hi_start);
                end
            end
            prev = Fsw; prev_busy = Busy;
            Up = 1'b0;
            if (!sent && m_cnt == 40) begin
                Up = 1'b1; sent = 1;
            end
        end
        n_chk++;
        if (!switched) begin
            n_fail++; $display("FAIL switch_timeout: got no switch expected one within 300 cycles");
        end
    endtask

    task automatic test_up_down_same;
        do_reset();
        En = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            n_chk++;
            if (Busy !== 1'b0 || Sel_out !== 2'd0 || obs_v !== exp_v) begin
                n_fail++; $display("FAIL up_down_same @%0d: got %b expected %b with Busy=0 Sel=0", i, obs_v, exp_v);
            end
            Up = (i == 3); Down = (i == 3);
        end
        Up = 1'b0; Down = 1'b0;
    endtask

    task automatic test_back_to_back;
        int j = -1;
        do_reset();
        En = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(negedge Clk);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL b2b_model @%0d: got %b expected %b", i, obs_v, exp_v);
            end
            Up = 1'b0;
            if (j < 0 && m_cnt == 40) begin
                Up = 1'b1; j = i;
            end else if (j >= 0 && i == j + 3) begin
                Up = 1'b1;
                n_chk++;
                if (Busy !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_busy: got %b expected 1", Busy);
                end
            end
        end
        n_chk++;
        if (Sel_out !== 2'd1 || Busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_single_step: got Sel=%0d Busy=%b expected 1/0", Sel_out, Busy);
        end
    endtask

    task automatic test_reset_mid_pending;
        int first_rise = -1;
        bit prev = 0;
        do_reset();
        En = 1'b1;
        for (int i = 0; i < 50 && m_cnt != 40; i++) @(negedge Clk);
        Up = 1'b1;
        @(negedge Clk);
        Up = 1'b0;
        @(negedge Clk);
        n_chk++;
        if (Busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_pending_busy: got %b expected 1", Busy);
        end
        @(posedge Clk);
        #2 Reset = 1'b1;
        #1;
        n_chk++;
        if (obs_v !== 5'b0) begin
            n_fail++; $display("FAIL async_reset: got %b expected 00000", obs_v);
        end
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge Clk);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL post_reset_model @%0d: got %b expected %b", i, obs_v, exp_v);
            end
            if (Fsw && !prev && first_rise < 0) first_rise = i;
            prev = Fsw;
        end
        n_chk++;
        if (first_rise != 32) begin
            n_fail++; $display("FAIL restart_rise: got %0d expected 32", first_rise);
        end
    endtask

    task automatic test_random;
        bit prev = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            n_chk++;
            if (obs_v !== exp_v) begin
                n_fail++; $display("FAIL random_model @%0d: got %b expected %b", i, obs_v, exp_v);
            end
            n_chk++;
            if (Tick !== (Fsw && !prev)) begin
                n_fail++; $display("FAIL random_tick @%0d: got %b expected %b", i, Tick, Fsw && !prev);
            end
            prev = Fsw;
            En   = $urandom_range(0, 7) != 0;
            Up   = $urandom_range(0, 15) == 0;
            Down = $urandom_range(0, 15) == 0;
        end
        Up = 1'b0; Down = 1'b0;
    endtask

    initial begin
        test_reset();
        test_period();
        test_down_at_zero();
        test_up_glitch();
        test_up_down_same();
        test_back_to_back();
        test_reset_mid_pending();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
